mem_stage_access_unit: RTL and testbench
========================================

// Module: mem_stage_access_unit
// PURPOSE
//  MEM stage of the 16-bit TSC pipeline; consumer side of the EX/MEM pipeline register.
//  Runs the data-memory req/ack handshake for loads and stores, stalls upstream while an access is outstanding.
//  Drives the MEM/WB-side outputs: retired instruction, writeback data, destination register.
//  Non-memory instructions pass straight through with 1-cycle latency.
// PARAMETERS
//  TIMEOUT_CYCLES  255  cycles in REQ without d_ack before abort (used only with MEM_ACCESS_TIMEOUT_EN)
// PORTS
//  clk            in   1   clock, rising edge
//  reset_n        in   1   asynchronous, active-low reset
//  flush          in   1   squash the instruction currently presented (IDLE only)
//  valid_in       in   1   EX/MEM holds a real instruction (0 = bubble)
//  pc_in          in   16  PC of the instruction
//  alu_result_in  in   16  ALU result; memory address for loads/stores
//  read_data2_in  in   16  store data
//  reg_dst_in     in   2   destination register index
//  mem_read_in    in   1   load
//  mem_write_in   in   1   store (mem_read_in && mem_write_in is illegal, treated as load)
//  reg_write_in   in   1   instruction writes the register file
//  d_req          out  1   memory request
//  d_we           out  1   1 = write, 0 = read; valid while d_req
//  d_addr         out  16  memory address; valid while d_req
//  d_wdata        out  16  write data; valid while d_req && d_we
//  d_ack          in   1   memory completion; sampled only while d_req
//  d_rdata        in   16  read data; valid in the d_ack cycle
//  mem_stall      out  1   hold EX/MEM and earlier stages (combinational: state==REQ)
//  wb_valid       out  1   instruction retired this cycle
//  wb_pc          out  16  PC of the retired instruction
//  wb_data        out  16  writeback value
//  wb_reg_dst     out  2   writeback register
//  wb_reg_write   out  1   register-file write enable (already qualified by wb_valid)
//  mem_error      out  1   sticky access-timeout flag
// BEHAVIOUR
//  Reset: state=IDLE; every registered output 0 (d_req, d_we, d_addr, d_wdata, wb_*, mem_error); counter 0.
//  Reset asserted in REQ: d_req falls immediately; the access is abandoned.
//  State IDLE, at each rising edge:
//   - flush || !valid_in: wb_valid<=0, wb_reg_write<=0; the instruction is dropped.
//   - Non-memory instruction: wb_valid<=1, wb_data<=alu_result_in, wb_pc/wb_reg_dst<=inputs, wb_reg_write<=reg_write_in.
//   - Memory instruction: latch pc/addr/wdata/reg_dst/reg_write/is_load; d_req<=1, d_we<=mem_write_in;
//     wb_valid<=0 (bubble into WB); state<=REQ.
//  State REQ: mem_stall=1, including the d_ack cycle, so the next EX/MEM instruction is held.
//   - No d_ack: hold all d_* outputs stable.
//   - d_ack at an edge: d_req<=0; wb_valid<=1; wb_pc/wb_reg_dst from the latch.
//     Load: wb_data<=d_rdata, wb_reg_write<=latched reg_write.
//     Store: wb_data<=latched addr, wb_reg_write<=0.
//     state<=IDLE.
//   - flush is ignored in REQ: the in-flight access is older than the flush and always completes.
//  Latency: non-mem 1 cycle; mem op = 1 + N cycles, N = number of REQ cycles up to and including the d_ack cycle (minimum 2 total).
//  wb_* hold their value for one cycle only: wb_valid is a pulse per retired instruction.
//  Only one outstanding access; d_req never re-asserts in the cycle after d_ack.
// CONFIGURATION
//  MEM_ACCESS_TIMEOUT_EN defined:
//   - 8-bit counter clears on entry to REQ and increments each REQ cycle without d_ack.
//   - When it reaches TIMEOUT_CYCLES: d_req<=0, mem_error<=1 (sticky until reset), wb_valid<=0, state<=IDLE.
//   - d_ack in the same cycle as the timeout wins: normal completion, no error.
//  MEM_ACCESS_TIMEOUT_EN undefined: REQ waits indefinitely; mem_error tied 0; no counter logic.
// TESTING
//  1. ALU op, alu_result=0x1234, reg_dst=2, reg_write=1 -> next cycle wb_valid=1, wb_data=0x1234,
//     wb_reg_dst=2, mem_stall=0 throughout.
//  2. Load addr 0x0040, d_ack on the 3rd REQ cycle with d_rdata=0xBEEF -> d_req=1 for 3 cycles, d_we=0,
//     mem_stall=1 for the same 3 cycles, then wb_valid=1, wb_data=0xBEEF.
//  3. Store addr 0x0080, data 0x5555, ack in the 1st REQ cycle; next instruction is an ALU op ->
//     d_we=1, d_wdata=0x5555, wb_reg_write=0; the ALU op retires exactly 1 cycle after the store.
//  4. Load presented with flush=1 in IDLE -> no d_req, wb_valid=0. flush=1 during REQ -> load still
//     completes with the correct wb_data.
//  5. reset_n low mid-REQ -> d_req=0 and all wb_* = 0 immediately; after release, an ALU op retires normally.
//  6. MEM_ACCESS_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, no d_ack -> d_req drops after 4 REQ cycles,
//     mem_error=1, wb_valid stays 0.

Source files
------------

// File: rtl/mem_stage_access_unit_if.sv
// Bundle of EX/MEM inputs, data-memory bus and MEM/WB outputs for mem_stage_access_unit.
// master = the MEM stage itself, slave = the surrounding pipeline / memory / bench.
interface mem_stage_access_unit_if;
  // EX/MEM pipeline register contents
  logic        flush;
  logic        valid_in;
  logic [15:0] pc_in;
  logic [15:0] alu_result_in;
  logic [15:0] read_data2_in;
  logic [1:0]  reg_dst_in;
  logic        mem_read_in;
  logic        mem_write_in;
  logic        reg_write_in;
  // Data memory: d_req rises with d_we/d_addr/d_wdata and holds them stable until the
  // first cycle d_ack is high; that cycle completes the access and d_req drops next edge.
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_ack;
  logic [15:0] d_rdata;
  // MEM/WB side
  logic        mem_stall;
  logic        wb_valid;
  logic [15:0] wb_pc;
  logic [15:0] wb_data;
  logic [1:0]  wb_reg_dst;
  logic        wb_reg_write;
  logic        mem_error;
  logic        dbg_state;

  modport master (
    input  flush, valid_in, pc_in, alu_result_in, read_data2_in, reg_dst_in,
           mem_read_in, mem_write_in, reg_write_in, d_ack, d_rdata,
    output d_req, d_we, d_addr, d_wdata, mem_stall, wb_valid, wb_pc, wb_data,
           wb_reg_dst, wb_reg_write, mem_error, dbg_state
  );

  modport slave (
    output flush, valid_in, pc_in, alu_result_in, read_data2_in, reg_dst_in,
           mem_read_in, mem_write_in, reg_write_in, d_ack, d_rdata,
    input  d_req, d_we, d_addr, d_wdata, mem_stall, wb_valid, wb_pc, wb_data,
           wb_reg_dst, wb_reg_write, mem_error, dbg_state
  );
endinterface

// File: rtl/mem_stage_access_unit.sv
// MEM stage of the 16-bit TSC pipeline: data-memory req/ack handshake, upstream stall, WB outputs.
// Optional access timeout with sticky mem_error is enabled by defining MEM_ACCESS_TIMEOUT_EN.
module mem_stage_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic                      clk,
  input logic                      reset_n,
  mem_stage_access_unit_if.master  bus
);
  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t      state;
  logic [15:0] lat_pc;
  logic [1:0]  lat_reg_dst;
  logic        lat_reg_write;
  logic        lat_is_load;
  logic        is_mem_op;
  logic        timeout_hit;

  assign is_mem_op     = bus.mem_read_in | bus.mem_write_in;
  assign bus.mem_stall = (state == REQ);
  assign bus.dbg_state = (state == REQ);

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] timeout_cnt;

  // An ack arriving on the last allowed cycle still completes the access normally.
  assign timeout_hit = !bus.d_ack && (timeout_cnt == TIMEOUT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timeout_cnt   <= '0;
      bus.mem_error <= 1'b0;
    end else if (state == IDLE) begin
      timeout_cnt <= '0;
    end else begin
      if (timeout_hit) bus.mem_error <= 1'b1;
      if (!bus.d_ack)  timeout_cnt   <= timeout_cnt + 8'd1;
    end
  end
`else
  logic unused_timeout;
  assign timeout_hit    = 1'b0;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign bus.mem_error  = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      bus.d_req        <= 1'b0;
      bus.d_we         <= 1'b0;
      bus.d_addr       <= '0;
      bus.d_wdata      <= '0;
      bus.wb_valid     <= 1'b0;
      bus.wb_pc        <= '0;
      bus.wb_data      <= '0;
      bus.wb_reg_dst   <= '0;
      bus.wb_reg_write <= 1'b0;
      lat_pc           <= '0;
      lat_reg_dst      <= '0;
      lat_reg_write    <= 1'b0;
      lat_is_load      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.flush || !bus.valid_in) begin
            bus.wb_valid     <= 1'b0;
            bus.wb_reg_write <= 1'b0;
          end else if (!is_mem_op) begin
            bus.wb_valid     <= 1'b1;
            bus.wb_pc        <= bus.pc_in;
            bus.wb_data      <= bus.alu_result_in;
            bus.wb_reg_dst   <= bus.reg_dst_in;
            bus.wb_reg_write <= bus.reg_write_in;
          end else begin
            // d_addr/d_wdata double as the latched address and store data.
            lat_pc           <= bus.pc_in;
            lat_reg_dst      <= bus.reg_dst_in;
            lat_reg_write    <= bus.reg_write_in;
            lat_is_load      <= bus.mem_read_in;
            bus.d_req        <= 1'b1;
            bus.d_we         <= bus.mem_write_in & ~bus.mem_read_in;
            bus.d_addr       <= bus.alu_result_in;
            bus.d_wdata      <= bus.read_data2_in;
            bus.wb_valid     <= 1'b0;
            bus.wb_reg_write <= 1'b0;
            state            <= REQ;
          end
        end
        REQ: begin
          if (bus.d_ack) begin
            bus.d_req        <= 1'b0;
            bus.d_we         <= 1'b0;
            bus.wb_valid     <= 1'b1;
            bus.wb_pc        <= lat_pc;
            bus.wb_reg_dst   <= lat_reg_dst;
            bus.wb_data      <= lat_is_load ? bus.d_rdata : bus.d_addr;
            bus.wb_reg_write <= lat_is_load & lat_reg_write;
            state            <= IDLE;
          end else if (timeout_hit) begin
            bus.d_req        <= 1'b0;
            bus.d_we         <= 1'b0;
            bus.wb_valid     <= 1'b0;
            bus.wb_reg_write <= 1'b0;
            state            <= IDLE;
          end else begin
            bus.wb_valid     <= 1'b0;
            bus.wb_reg_write <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage_access_unit.sv
// Directed bench for mem_stage_access_unit: ALU-op vector table plus load/store/flush/reset/timeout sequences.
module tb_mem_stage_access_unit;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_data;

  always #5 clk = ~clk;

  mem_stage_access_unit_if bus ();

  mem_stage_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic        valid;
    logic        flush;
    logic [15:0] pc;
    logic [15:0] alu;
    logic [1:0]  dst;
    logic        rw;
    logic        exp_valid;
    logic [15:0] exp_data;
    logic        exp_rw;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_alu(input logic valid, input logic flush, input logic [15:0] pc,
                           input logic [15:0] alu, input logic [1:0] dst, input logic rw);
    bus.valid_in      = valid;
    bus.flush         = flush;
    bus.pc_in         = pc;
    bus.alu_result_in = alu;
    bus.read_data2_in = 16'h0000;
    bus.reg_dst_in    = dst;
    bus.mem_read_in   = 1'b0;
    bus.mem_write_in  = 1'b0;
    bus.reg_write_in  = rw;
  endtask

  task automatic drive_mem(input logic [15:0] pc, input logic [15:0] addr, input logic [15:0] wdata,
                           input logic [1:0] dst, input logic rw, input logic is_load);
    bus.valid_in      = 1'b1;
    bus.flush         = 1'b0;
    bus.pc_in         = pc;
    bus.alu_result_in = addr;
    bus.read_data2_in = wdata;
    bus.reg_dst_in    = dst;
    bus.mem_read_in   = is_load;
    bus.mem_write_in  = !is_load;
    bus.reg_write_in  = rw;
  endtask

  task automatic drive_idle();
    drive_alu(1'b0, 1'b0, 16'h0000, 16'h0000, 2'd0, 1'b0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 16'h0010, 16'h1234, 2'd2, 1'b1, 1'b1, 16'h1234, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 16'h0012, 16'hABCD, 2'd1, 1'b0, 1'b1, 16'hABCD, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 16'h0014, 16'h5A5A, 2'd3, 1'b1, 1'b0, 16'h0000, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 16'h0016, 16'h7777, 2'd2, 1'b1, 1'b0, 16'h0000, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 16'hFFFE, 16'hFFFF, 2'd3, 1'b1, 1'b1, 16'hFFFF, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 2'd0, 1'b1, 1'b1, 16'h0000, 1'b1};

    // Clock/reset
    drive_idle();
    bus.d_ack   = 1'b0;
    bus.d_rdata = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check("reset d_req", {15'd0, bus.d_req}, 16'd0);
    check("reset wb_valid", {15'd0, bus.wb_valid}, 16'd0);
    check("reset wb_data", bus.wb_data, 16'h0000);
    check("reset mem_stall", {15'd0, bus.mem_stall}, 16'd0);
    check("reset mem_error", {15'd0, bus.mem_error}, 16'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Non-memory vector table
    for (int i = 0; i < 6; i++) begin
      drive_alu(vecs[i].valid, vecs[i].flush, vecs[i].pc, vecs[i].alu, vecs[i].dst, vecs[i].rw);
      if (vecs[i].exp_valid) exp_q.push_back(vecs[i].exp_data);
      tick();
      check($sformatf("vec%0d wb_valid", i), {15'd0, bus.wb_valid}, {15'd0, vecs[i].exp_valid});
      check($sformatf("vec%0d wb_reg_write", i), {15'd0, bus.wb_reg_write}, {15'd0, vecs[i].exp_rw});
      check($sformatf("vec%0d mem_stall", i), {15'd0, bus.mem_stall}, 16'd0);
      check($sformatf("vec%0d d_req", i), {15'd0, bus.d_req}, 16'd0);
      if (vecs[i].exp_valid) begin
        exp_data = exp_q.pop_front();
        check($sformatf("vec%0d wb_data", i), bus.wb_data, exp_data);
        check($sformatf("vec%0d wb_pc", i), bus.wb_pc, vecs[i].pc);
        check($sformatf("vec%0d wb_reg_dst", i), {14'd0, bus.wb_reg_dst}, {14'd0, vecs[i].dst});
      end
    end

    // Load, ack on 3rd REQ cycle
    drive_mem(16'h0020, 16'h0040, 16'h0000, 2'd1, 1'b1, 1'b1);
    for (int c = 1; c <= 3; c++) begin
      tick();
      check($sformatf("load c%0d d_req", c), {15'd0, bus.d_req}, 16'd1);
      check($sformatf("load c%0d mem_stall", c), {15'd0, bus.mem_stall}, 16'd1);
      check($sformatf("load c%0d d_we", c), {15'd0, bus.d_we}, 16'd0);
      check($sformatf("load c%0d d_addr", c), bus.d_addr, 16'h0040);
      check($sformatf("load c%0d wb_valid", c), {15'd0, bus.wb_valid}, 16'd0);
    end
    bus.d_ack   = 1'b1;
    bus.d_rdata = 16'hBEEF;
    drive_idle();
    tick();
    bus.d_ack = 1'b0;
    check("load wb_valid", {15'd0, bus.wb_valid}, 16'd1);
    check("load wb_data", bus.wb_data, 16'hBEEF);
    check("load wb_pc", bus.wb_pc, 16'h0020);
    check("load wb_reg_dst", {14'd0, bus.wb_reg_dst}, 16'd1);
    check("load wb_reg_write", {15'd0, bus.wb_reg_write}, 16'd1);
    check("load d_req after ack", {15'd0, bus.d_req}, 16'd0);
    check("load mem_stall after ack", {15'd0, bus.mem_stall}, 16'd0);
    tick();
    check("load wb_valid pulse", {15'd0, bus.wb_valid}, 16'd0);

    // Store acked in 1st REQ cycle, ALU op waiting behind it
    drive_mem(16'h0030, 16'h0080, 16'h5555, 2'd2, 1'b1, 1'b0);
    tick();
    check("store d_req", {15'd0, bus.d_req}, 16'd1);
    check("store d_we", {15'd0, bus.d_we}, 16'd1);
    check("store d_wdata", bus.d_wdata, 16'h5555);
    check("store d_addr", bus.d_addr, 16'h0080);
    bus.d_ack = 1'b1;
    drive_alu(1'b1, 1'b0, 16'h0032, 16'h0099, 2'd3, 1'b1);
    tick();
    bus.d_ack = 1'b0;
    check("store wb_valid", {15'd0, bus.wb_valid}, 16'd1);
    check("store wb_reg_write", {15'd0, bus.wb_reg_write}, 16'd0);
    check("store wb_data", bus.wb_data, 16'h0080);
    check("store d_req after ack", {15'd0, bus.d_req}, 16'd0);
    tick();
    drive_idle();
    check("alu after store wb_valid", {15'd0, bus.wb_valid}, 16'd1);
    check("alu after store wb_data", bus.wb_data, 16'h0099);
    check("alu after store wb_pc", bus.wb_pc, 16'h0032);
    check("no re-req after ack", {15'd0, bus.d_req}, 16'd0);

    // Flush in IDLE drops the load; flush in REQ is ignored
    drive_mem(16'h0040, 16'h0100, 16'h0000, 2'd2, 1'b1, 1'b1);
    bus.flush = 1'b1;
    tick();
    check("flush idle d_req", {15'd0, bus.d_req}, 16'd0);
    check("flush idle wb_valid", {15'd0, bus.wb_valid}, 16'd0);
    bus.flush = 1'b0;
    tick();
    check("flush req d_req", {15'd0, bus.d_req}, 16'd1);
    bus.flush = 1'b1;
    tick();
    check("flush req held", {15'd0, bus.d_req}, 16'd1);
    bus.d_ack   = 1'b1;
    bus.d_rdata = 16'h1357;
    tick();
    bus.d_ack = 1'b0;
    drive_idle();
    check("flush req wb_valid", {15'd0, bus.wb_valid}, 16'd1);
    check("flush req wb_data", bus.wb_data, 16'h1357);

`ifdef MEM_ACCESS_TIMEOUT_EN
    // No ack: abort after 4 REQ cycles
    drive_mem(16'h0050, 16'h0200, 16'h0000, 2'd1, 1'b1, 1'b1);
    tick();
    drive_idle();
    check("timeout c1 d_req", {15'd0, bus.d_req}, 16'd1);
    for (int c = 2; c <= 4; c++) begin
      tick();
      check($sformatf("timeout c%0d d_req", c), {15'd0, bus.d_req}, 16'd1);
      check($sformatf("timeout c%0d mem_error", c), {15'd0, bus.mem_error}, 16'd0);
    end
    tick();
    check("timeout d_req", {15'd0, bus.d_req}, 16'd0);
    check("timeout mem_error", {15'd0, bus.mem_error}, 16'd1);
    check("timeout wb_valid", {15'd0, bus.wb_valid}, 16'd0);
    check("timeout mem_stall", {15'd0, bus.mem_stall}, 16'd0);
    tick();
    check("timeout mem_error sticky", {15'd0, bus.mem_error}, 16'd1);
    check("timeout wb_valid stays 0", {15'd0, bus.wb_valid}, 16'd0);
`else
    // No timeout: REQ waits for a late ack
    drive_mem(16'h0050, 16'h0200, 16'h0000, 2'd1, 1'b1, 1'b1);
    tick();
    drive_idle();
    for (int c = 1; c <= 10; c++) begin
      check($sformatf("long wait c%0d d_req", c), {15'd0, bus.d_req}, 16'd1);
      tick();
    end
    bus.d_ack   = 1'b1;
    bus.d_rdata = 16'h2468;
    tick();
    bus.d_ack = 1'b0;
    check("long wait wb_valid", {15'd0, bus.wb_valid}, 16'd1);
    check("long wait wb_data", bus.wb_data, 16'h2468);
    check("long wait mem_error", {15'd0, bus.mem_error}, 16'd0);
`endif

    // Reset in the middle of REQ
    drive_mem(16'h0060, 16'h0300, 16'h0000, 2'd3, 1'b1, 1'b1);
    tick();
    check("pre-reset d_req", {15'd0, bus.d_req}, 16'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid reset d_req", {15'd0, bus.d_req}, 16'd0);
    check("mid reset wb_valid", {15'd0, bus.wb_valid}, 16'd0);
    check("mid reset wb_data", bus.wb_data, 16'h0000);
    check("mid reset wb_pc", bus.wb_pc, 16'h0000);
    check("mid reset wb_reg_dst", {14'd0, bus.wb_reg_dst}, 16'd0);
    check("mid reset wb_reg_write", {15'd0, bus.wb_reg_write}, 16'd0);
    check("mid reset mem_stall", {15'd0, bus.mem_stall}, 16'd0);
    check("mid reset mem_error", {15'd0, bus.mem_error}, 16'd0);
    @(negedge clk);
    reset_n = 1'b1;
    drive_alu(1'b1, 1'b0, 16'h0070, 16'h4321, 2'd1, 1'b1);
    tick();
    drive_idle();
    check("post reset wb_valid", {15'd0, bus.wb_valid}, 16'd1);
    check("post reset wb_data", bus.wb_data, 16'h4321);
    check("post reset wb_reg_dst", {14'd0, bus.wb_reg_dst}, 16'd1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
